bin_to_bcd_display: RTL

- Sequential double-dabble converter between the CPU's 16-bit binary output register and the 4-digit seven-segment driver.
- Accepts a binary value on a start strobe and converts it iteratively, one bit per clock.
- Holds a packed 4-digit BCD word stable for the display driver's din input until the next conversion completes.
- Flags values that cannot be shown in 4 decimal digits.

---
 rtl/bin_to_bcd_display.sv | 117 +++++++++++
 1 files changed

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter for the 4-digit display.
// Optional macro OVF_HEX_EN: on overflow show raw hex instead of 9999.
module bin_to_bcd_display #(
  parameter int unsigned ITER    = 16,
  parameter int unsigned MAX_DEC = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] bcd_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t      state_q;
  logic [15:0] shreg_q;
  logic [15:0] shreg_d;
  logic [19:0] scr_q;
  logic [19:0] scr_d;
  logic [19:0] scr_adj;
  logic [4:0]  cnt_q;
  logic        cmp_ovf_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic [15:0] bcd_q;
  logic [15:0] ovf_val;

`ifdef OVF_HEX_EN
  logic [15:0] raw_q;

  // Keep the accepted value, the shift register is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '0;
    end else if (state_q == IDLE && start) begin
      raw_q <= bin_in;
    end
  end

  assign ovf_val = raw_q;
`else
  assign ovf_val = 16'h9999;
`endif

  // Add-3 on every digit >= 5, then shift scratch:shreg left one bit
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < 5; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    {scr_d, shreg_d} = {scr_adj[18:0], shreg_q, 1'b0};
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      cmp_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q   <= bin_in;
            scr_q     <= '0;
            cnt_q     <= '0;
            cmp_ovf_q <= (bin_in > 16'(MAX_DEC));
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q   <= scr_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) begin
            state_q <= LATCH;
          end
        end
        LATCH: begin
          bcd_q   <= cmp_ovf_q ? ovf_val : scr_q[15:0];
          ovf_q   <= cmp_ovf_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign bcd_out = bcd_q;

endmodule
